eva_axi_wr_arb: RTL
===================

# eva_axi_wr_arb

Two-to-one AXI write-channel arbiter in front of the EVA AXI slave port (the 64-bit-address, 128-bit-data, 6-bit-ID write interface). It shares that single write port between two upstream masters. Write-address requests are granted round-robin, and a grant is held stable until it is accepted. Write data is steered in address-grant order through an outstanding-order FIFO. Write responses are routed back by the ID bit the arbiter inserts.

## Interface
- OST_DEPTH, 4: outstanding AW grants whose W burst has not yet completed (power of 2, 2..16).
- aclk  in  1  clock.
- arest  in  1  asynchronous active-high reset.
- sN_awvalid/sN_awready  in/out  1  upstream AW handshake (N = 0,1).
- sN_awid  in  5  upstream ID.
- sN_awaddr  in  64 ; sN_awlen in 6 ; sN_awsize in 3 ; sN_awburst in 2 ; sN_awuser in 8  AW payload.
- sN_wvalid/sN_wready  in/out  1 ; sN_wlast in 1 ; sN_wdata in 128 ; sN_wstrb in 16  upstream W.
- sN_bvalid out 1 ; sN_bready in 1 ; sN_bid out 5 ; sN_bresp out 2  upstream B.
- m_awvalid out 1 ; m_awready in 1 ; m_awid out 6 ; m_awaddr out 64 ; m_awlen out 6 ; m_awsize out 3 ; m_awburst out 2 ; m_awuser out 8  downstream AW.
- m_wvalid out 1 ; m_wready in 1 ; m_wlast out 1 ; m_wid out 6 ; m_wdata out 128 ; m_wstrb out 16  downstream W.
- m_bvalid in 1 ; m_bready out 1 ; m_bid in 6 ; m_bresp in 2  downstream B.

## Operation
- AW arbitration:
  - State flops: `gnt` (1 bit), `aw_hold` (1 bit), `rr_last` (1 bit, last master served).
  - When `aw_hold` is 0, `gnt` is chosen combinationally. If only one master has awvalid, that master wins. If both do, the master other than `rr_last` wins.
  - m_awvalid = sgnt_awvalid & !fifo_full. The payload is muxed from sgnt. m_awid = {gnt, sgnt_awid}.
  - If m_awvalid is high and m_awready is low, set `aw_hold` and freeze `gnt`. Clear `aw_hold` on the handshake.
  - On the handshake (m_awvalid & m_awready): sgnt_awready = 1, push `gnt` into the order FIFO, and set rr_last <= gnt.
  - The non-granted master's awready = 0. Both awready = 0 when the FIFO is full.
- Order FIFO:
  - OST_DEPTH entries of 1 bit each. Read pointer, write pointer and count each use log2(OST_DEPTH)+1 bits. Pointers wrap modulo OST_DEPTH.
  - Push and pop in the same cycle leaves the count unchanged. When the FIFO is full, a push is impossible because m_awvalid is gated.
- W steering:
  - When the FIFO is empty, m_wvalid = 0 and both wready = 0.
  - Otherwise `head` selects the master: m_wvalid = shead_wvalid. W payload and wlast are muxed from head. m_wid = {head, 5'b0}.
  - shead_wready = m_wready. The other master's wready = 0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - The arbiter neither checks nor rewrites burst length. wlast is trusted.
- B routing:
  - sel = m_bid[5]. ssel_bvalid = m_bvalid, ssel_bid = m_bid[4:0], ssel_bresp = m_bresp, m_bready = ssel_bready.
  - The other master's bvalid = 0.
  - B routing carries no state and is independent of the AW and W logic.
- Reset:
  - All flops are cleared: gnt = 0, aw_hold = 0, rr_last = 1 (so s0 wins the first tie), FIFO empty.
  - While arest is high, every output is forced to 0 (valid, ready and payload).
  - Asserting arest mid-burst discards all outstanding order state. Upstream and downstream must be reset together.

## Timing
- AW path is combinational: 0-cycle latency from sN_awvalid to m_awvalid.
- W of a burst is forwarded no earlier than the cycle after its AW handshake. The push becomes visible at the next edge. W presented in the same cycle as its own AW is stalled 1 cycle.
- Back-to-back bursts:
  - A pop and the next head switch take effect in the same edge. The next burst's first beat can transfer in the cycle immediately after the previous wlast beat.
  - Sustained throughput is 1 AW per cycle and 1 W beat per cycle.
- B path is combinational: 0 cycles.
- No combinational path from m_awready to m_awvalid, nor from m_wready to m_wvalid.

## Configuration
- EVA_WR_ARB_FIXED_PRI_EN:
  - Defined: s0 always wins when both masters request, and rr_last is unused. The hold-until-accepted rule still applies.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- s0 and s1 both raise awvalid at the first cycle after reset, with m_awready = 1. The required response is:
  - Grant sequence s0, s1, s0, s1.
  - m_awid = 0x20|id for s1 and id for s0.
  - Under EVA_WR_ARB_FIXED_PRI_EN, s0 is granted every cycle.
- s1 wins the grant, m_awready is held 0 for 3 cycles, and s0 raises awvalid during the stall. The required response is:
  - gnt stays 1 and m_awaddr stays on s1's address for all 3 cycles.
  - s1_awready pulses exactly once, when m_awready goes to 1.
- OST_DEPTH = 4, five AW accepted with no W activity. The required response is:
  - The fifth AW is stalled: m_awvalid = 0 and both awready = 0.
  - After one wlast beat completes, the fifth AW is accepted in the next cycle.
- AW order s1 (awlen 3), s0 (awlen 0), with s0 presenting W first. The required response is:
  - s0_wready stays 0 until s1's fourth beat (wlast) completes.
  - s0's single beat then transfers in the following cycle.
- m_bvalid with m_bid = 0x25, bresp 2'b10. The required response is:
  - s1_bvalid = 1, s1_bid = 5, s1_bresp = 2'b10, s0_bvalid = 0.
  - m_bready follows s1_bready.
- arest asserted mid-W-burst with 2 entries outstanding. The required response is:
  - All outputs go to 0 asynchronously.
  - After release, the FIFO is empty and the first tie is granted to s0.

Source files
------------

// File: rtl/eva_axi_wr_arb.sv
// Two-to-one AXI write-channel arbiter in front of the EVA AXI slave port.
// Grants AW round-robin and holds each grant until it is accepted. W beats are
// steered in AW-grant order through a small order FIFO. B responses are routed
// by the ID bit that the arbiter inserts.
// Optional build macro EVA_WR_ARB_FIXED_PRI_EN gives s0 fixed priority on ties.
module eva_axi_wr_arb #(
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic         aclk,
  input  logic         arest,
  // upstream master 0
  input  logic         s0_awvalid,
  output logic         s0_awready,
  input  logic [4:0]   s0_awid,
  input  logic [63:0]  s0_awaddr,
  input  logic [5:0]   s0_awlen,
  input  logic [2:0]   s0_awsize,
  input  logic [1:0]   s0_awburst,
  input  logic [7:0]   s0_awuser,
  input  logic         s0_wvalid,
  output logic         s0_wready,
  input  logic         s0_wlast,
  input  logic [127:0] s0_wdata,
  input  logic [15:0]  s0_wstrb,
  output logic         s0_bvalid,
  input  logic         s0_bready,
  output logic [4:0]   s0_bid,
  output logic [1:0]   s0_bresp,
  // upstream master 1
  input  logic         s1_awvalid,
  output logic         s1_awready,
  input  logic [4:0]   s1_awid,
  input  logic [63:0]  s1_awaddr,
  input  logic [5:0]   s1_awlen,
  input  logic [2:0]   s1_awsize,
  input  logic [1:0]   s1_awburst,
  input  logic [7:0]   s1_awuser,
  input  logic         s1_wvalid,
  output logic         s1_wready,
  input  logic         s1_wlast,
  input  logic [127:0] s1_wdata,
  input  logic [15:0]  s1_wstrb,
  output logic         s1_bvalid,
  input  logic         s1_bready,
  output logic [4:0]   s1_bid,
  output logic [1:0]   s1_bresp,
  // downstream slave port
  output logic         m_awvalid,
  input  logic         m_awready,
  output logic [5:0]   m_awid,
  output logic [63:0]  m_awaddr,
  output logic [5:0]   m_awlen,
  output logic [2:0]   m_awsize,
  output logic [1:0]   m_awburst,
  output logic [7:0]   m_awuser,
  output logic         m_wvalid,
  input  logic         m_wready,
  output logic         m_wlast,
  output logic [5:0]   m_wid,
  output logic [127:0] m_wdata,
  output logic [15:0]  m_wstrb,
  input  logic         m_bvalid,
  output logic         m_bready,
  input  logic [5:0]   m_bid,
  input  logic [1:0]   m_bresp
);

  localparam int unsigned PtrW = $clog2(OST_DEPTH) + 1;
  localparam int unsigned IdxW = PtrW - 1;

  logic                 gnt_q, gnt;
  logic                 aw_hold_q;
  logic [OST_DEPTH-1:0] ord_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, cnt_q;
  logic                 fifo_full, fifo_empty, head;
  logic                 sgnt_awvalid, aw_valid, aw_hs;
  logic                 w_valid, w_last, pop;
`ifndef EVA_WR_ARB_FIXED_PRI_EN
  logic                 rr_last_q;
`endif

  assign fifo_full  = (cnt_q == PtrW'(OST_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = ord_q[rd_ptr_q[IdxW-1:0]];

  // Grant selection: frozen while a stalled request is held, else arbitrate.
  always_comb begin
    gnt = gnt_q;
    if (!aw_hold_q) begin
      if (s0_awvalid && !s1_awvalid) begin
        gnt = 1'b0;
      end else if (s1_awvalid && !s0_awvalid) begin
        gnt = 1'b1;
      end else if (s0_awvalid && s1_awvalid) begin
`ifdef EVA_WR_ARB_FIXED_PRI_EN
        gnt = 1'b0;
`else
        gnt = ~rr_last_q;
`endif
      end
    end
  end

  // Handshake and steering terms; none depends on a ready toward its own valid.
  always_comb begin
    sgnt_awvalid = gnt ? s1_awvalid : s0_awvalid;
    aw_valid     = sgnt_awvalid & ~fifo_full;
    aw_hs        = aw_valid & m_awready;
    w_valid      = ~fifo_empty & (head ? s1_wvalid : s0_wvalid);
    w_last       = head ? s1_wlast : s0_wlast;
    pop          = w_valid & m_wready & w_last;
  end

  // Grant and hold state: hold is set by a stalled request, cleared on acceptance.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      gnt_q     <= 1'b0;
      aw_hold_q <= 1'b0;
    end else begin
      gnt_q <= gnt;
      if (aw_hs) begin
        aw_hold_q <= 1'b0;
      end else if (aw_valid) begin
        aw_hold_q <= 1'b1;
      end
    end
  end

`ifndef EVA_WR_ARB_FIXED_PRI_EN
  // Last master served; resets to s1 so that s0 wins the first tie.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      rr_last_q <= 1'b1;
    end else if (aw_hs) begin
      rr_last_q <= gnt;
    end
  end
`endif

  // Order FIFO: records which master owns each outstanding W burst.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      ord_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (aw_hs) begin
        ord_q[wr_ptr_q[IdxW-1:0]] <= gnt;
        wr_ptr_q                  <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (aw_hs && !pop) begin
        cnt_q <= cnt_q + PtrW'(1);
      end else if (pop && !aw_hs) begin
        cnt_q <= cnt_q - PtrW'(1);
      end
    end
  end

  // Output muxing; every output is held at zero while reset is asserted.
  always_comb begin
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    s0_bid     = '0;
    s1_bid     = '0;
    s0_bresp   = '0;
    s1_bresp   = '0;
    m_awvalid  = 1'b0;
    m_awid     = '0;
    m_awaddr   = '0;
    m_awlen    = '0;
    m_awsize   = '0;
    m_awburst  = '0;
    m_awuser   = '0;
    m_wvalid   = 1'b0;
    m_wlast    = 1'b0;
    m_wid      = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    if (!arest) begin
      m_awvalid  = aw_valid;
      m_awid     = {gnt, (gnt ? s1_awid : s0_awid)};
      m_awaddr   = gnt ? s1_awaddr  : s0_awaddr;
      m_awlen    = gnt ? s1_awlen   : s0_awlen;
      m_awsize   = gnt ? s1_awsize  : s0_awsize;
      m_awburst  = gnt ? s1_awburst : s0_awburst;
      m_awuser   = gnt ? s1_awuser  : s0_awuser;
      s0_awready = aw_hs & ~gnt;
      s1_awready = aw_hs & gnt;
      m_wvalid   = w_valid;
      m_wlast    = w_last;
      m_wid      = {head, 5'b0};
      m_wdata    = head ? s1_wdata : s0_wdata;
      m_wstrb    = head ? s1_wstrb : s0_wstrb;
      s0_wready  = ~fifo_empty & ~head & m_wready;
      s1_wready  = ~fifo_empty & head & m_wready;
      if (m_bid[5]) begin
        s1_bvalid = m_bvalid;
        s1_bid    = m_bid[4:0];
        s1_bresp  = m_bresp;
        m_bready  = s1_bready;
      end else begin
        s0_bvalid = m_bvalid;
        s0_bid    = m_bid[4:0];
        s0_bresp  = m_bresp;
        m_bready  = s0_bready;
      end
    end
  end

endmodule
